// File: rtl/output_bcd_converter_pkg.sv
// Shared definitions for the sequential double-dabble output BCD converter.
package output_bcd_converter_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam int BCD_DIGIT_W       = 4;
  localparam int BCD_ADJ_THRESHOLD = 5;
  localparam int BCD_ADJ_ADD       = 3;

endpackage

// File: rtl/output_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: a 4-bit "add 3 if >= 5" with no carry out.
// The largest adjusted value is 12, so the result always fits in 4 bits.
module bcd_digit_adjust
  import output_bcd_converter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Add 3 to a digit of 5 or more so that the next left shift carries correctly.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(BCD_ADJ_THRESHOLD)) begin
      o_digit = i_digit + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/output_bcd_converter.sv
// Sequential binary-to-BCD converter for the seven-segment display path.
// A conversion runs IDLE -> SHIFT (WIDTH cycles) -> DONE; BCD only changes
// in DONE, so the display never sees intermediate scratch values.
// Optional feature macro: OUTPUT_BCD_AUTO_START_EN -- when defined, a change
// of BIN relative to the last converted value also starts a conversion.
module output_bcd_converter
  import output_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [WIDTH-1:0]              BIN,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  bcd_state_e             r_state;
  bcd_state_e             w_state_nxt;
  logic [WIDTH-1:0]       r_bin;
  logic [SCR_W-1:0]       r_scratch;
  logic [CNT_W-1:0]       r_cnt;
  logic [SCR_W-1:0]       r_bcd;
  logic                   r_busy;
  logic                   r_done;
  logic [SCR_W-1:0]       w_adj;
  logic [SCR_W+WIDTH-1:0] w_shift;
  logic                   w_start;
  logic                   w_last_shift;

`ifdef OUTPUT_BCD_AUTO_START_EN
  logic [WIDTH-1:0] r_last_bin;

  assign w_start = START | (BIN != r_last_bin);

  // Remember the value of the last accepted conversion so changes retrigger.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last_bin <= {WIDTH{1'b0}};
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_last_bin <= BIN;
    end else begin
      r_last_bin <= r_last_bin;
    end
  end
`else
  assign w_start = START;
`endif

  // One adjust cell per scratch digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_shift      = {w_adj, r_bin} << 1;
  assign w_last_shift = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state selection for the conversion sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: capture, shift/adjust, result publication and output flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bin     <= {WIDTH{1'b0}};
      r_scratch <= {SCR_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_bcd     <= {SCR_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_SHIFT);
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bin     <= BIN;
            r_scratch <= {SCR_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_shift[SCR_W+WIDTH-1:WIDTH];
          r_bin     <= w_shift[WIDTH-1:0];
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_bcd  <= r_scratch;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign BCD  = r_bcd;

endmodule

// File: tb/tb_output_bcd_converter.sv
// Self-checking bench for output_bcd_converter: a cycle-count model of the
// conversion timeline plus decimal arithmetic for the expected digits.
module tb_output_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              START = 1'b0;
  logic [WIDTH-1:0]  BIN = '0;
  logic              BUSY;
  logic              DONE;
  logic [4*DIGITS-1:0] BCD;

  output_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BIN(BIN),
    .BUSY(BUSY), .DONE(DONE), .BCD(BCD)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  // Model: m_age = 0 when idle, else cycles since accepted start (1..WIDTH+1).
  int              m_age  = 0;
  logic [WIDTH-1:0] m_val = '0;
  logic [WIDTH-1:0] m_last = '0;
  logic [11:0]     m_bcd  = '0;
  logic            m_done = 1'b0;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update model from the applied inputs, then compare.
  task automatic tick();
    logic st;
    @(posedge CLK);
    if (RESET) begin
      m_age = 0; m_bcd = '0; m_done = 1'b0; m_last = '0;
    end else begin
      m_done = 1'b0;
      st = START;
`ifdef OUTPUT_BCD_AUTO_START_EN
      st = START | (BIN != m_last);
`endif
      if (m_age == 0) begin
        if (st) begin
          m_age = 1; m_val = BIN; m_last = BIN;
        end
      end else if (m_age == WIDTH + 1) begin
        m_age = 0; m_done = 1'b1; m_bcd = to_bcd(int'(m_val));
      end else begin
        m_age++;
      end
    end
    @(negedge CLK);
    chk("busy", BUSY, (m_age >= 1 && m_age <= WIDTH));
    chk("done", DONE, m_done);
    chk("bcd", BCD, m_bcd);
    if (DONE) n_done++;
  endtask

  // One full conversion from IDLE; returns the number of BUSY-high cycles.
  task automatic run_conv(input logic [WIDTH-1:0] v, output int busy_cycles);
    busy_cycles = 0;
    BIN = v; START = 1'b1;
    tick();
    if (BUSY) busy_cycles++;
    START = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      tick();
      if (BUSY) busy_cycles++;
    end
  endtask

  initial begin
    int bc;
    int d0;
    // Reset for two cycles, then idle.
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_bcd", BCD, 12'h000);
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_no_done", n_done, 0);

`ifndef OUTPUT_BCD_AUTO_START_EN
    // 255: eight BUSY cycles, DONE on the ninth edge after start.
    d0 = n_done;
    run_conv(8'd255, bc);
    chk("c255_busy_len", bc, 8);
    chk("c255_done", DONE, 1'b1);
    chk("c255_bcd", BCD, 12'h255);

    // 100 then 0 back-to-back; 0x100 must hold during the second conversion.
    run_conv(8'd100, bc);
    chk("c100_bcd", BCD, 12'h100);
    BIN = 8'd0; START = 1'b1;
    tick();
    START = 1'b0;
    chk("b2b_accepted", BUSY, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("c100_hold", BCD, 12'h100);
    for (int i = 0; i < 4; i++) tick();
    chk("c0_done", DONE, 1'b1);
    chk("c0_bcd", BCD, 12'h000);

    // 37 with a second START at cycle 3 that must be ignored.
    d0 = n_done;
    BIN = 8'd37; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    BIN = 8'd200; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("c37_bcd", BCD, 12'h037);
    for (int i = 0; i < 10; i++) tick();
    chk("c37_one_done", n_done - d0, 1);
    chk("c37_still", BCD, 12'h037);

    // 99 aborted by RESET at cycle 4.
    d0 = n_done;
    BIN = 8'd99; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_bcd", BCD, 12'h000);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_no_done", n_done - d0, 0);
`else
    // Auto-start: START tied low, BIN 0 -> 42 -> 42 -> 7.
    d0 = n_done;
    BIN = 8'd42;
    for (int i = 0; i < 12; i++) tick();
    chk("auto_42", BCD, 12'h042);
    for (int i = 0; i < 12; i++) tick();
    BIN = 8'd7;
    for (int i = 0; i < 12; i++) tick();
    chk("auto_7", BCD, 12'h007);
    chk("auto_two_done", n_done - d0, 2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      START = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) BIN = WIDTH'($urandom);
      RESET = ($urandom_range(0, 199) == 0);
      tick();
    end
    RESET = 1'b0; START = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/output_bcd_converter.md
Name: output_bcd_converter

Overview:
- Sequential double-dabble binary-to-BCD converter on the output side of the CPU.
- Consumes the 8-bit value on data-memory output port 0 and produces registered, glitch-free decimal digits (hundreds/tens/ones) for the seven-segment display scanner.
- Replaces the combinational converter; a conversion takes a fixed number of cycles and is framed by a start/busy/done handshake.

Parameters:
- WIDTH, 8, binary input width in bits.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a conversion of BIN; sampled only in IDLE.
- BIN  input  WIDTH  binary value to convert; captured on the accepted START edge.
- BUSY  output  1  high while a conversion is in progress (SHIFT state).
- DONE  output  1  one-cycle pulse when BCD has just been updated.
- BCD  output  4*DIGITS  packed result; [3:0]=ones, [7:4]=tens, [11:8]=hundreds.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values: state=IDLE, BUSY=0, DONE=0, BCD=0, shift registers=0.
- FSM states:
  - IDLE: on START=1, load BIN into the binary shift register, clear the BCD scratch register and the shift counter, then go to SHIFT.
  - SHIFT: each cycle, every scratch digit that is >=5 gets +3. Then {scratch, binary} shifts left by 1 and the counter increments. After WIDTH shifts, go to DONE.
  - DONE: copy scratch to the BCD output register, pulse DONE for 1 cycle, return to IDLE.
- Latency: START sampled at edge 0 → BCD valid and DONE=1 after edge WIDTH+1, i.e. 9 cycles for WIDTH=8. The next START can be accepted in the cycle after DONE.
- BUSY=1 exactly in SHIFT cycles and 0 in IDLE/DONE.
- BCD holds the last completed result and never shows intermediate values.
- START while BUSY or in DONE is ignored, not queued.
- BIN changes after capture do not affect the conversion in flight.
- RESET asserted mid-conversion aborts it: next cycle is IDLE, BCD=0, no DONE pulse.
- Widths: the adjust is a 4-bit add with no carry out; the adjusted digit is at most 12, so it is always representable. Counter width is clog2(WIDTH+1).

Optional Feature:
- Macro: OUTPUT_BCD_AUTO_START_EN.
- Defined:
  - An internal register last_bin (reset 0) holds the BIN value of the last accepted conversion.
  - In IDLE, a conversion also starts when BIN != last_bin (ORed with START).
  - last_bin is updated on every accepted start.
  - Effect: the display tracks port 0 with no CPU involvement.
- Undefined: last_bin does not exist; conversions start only on START.

Decomposition:
- Shared package:
  - State enum {IDLE, SHIFT, DONE}.
  - BCD_DIGIT_W=4.
  - BCD_ADJ_THRESHOLD=5.
  - BCD_ADJ_ADD=3.
- Sub-module: bcd_digit_adjust, a combinational 4-bit "add 3 if >=5". One instance per digit, generated DIGITS times.

Test Plan:
- RESET for 2 cycles, then idle → BCD=0x000, BUSY=0, DONE never pulses.
- BIN=255, START one cycle → BUSY high for 8 cycles, DONE at cycle 9, BCD=0x255.
- BIN=100, then BIN=0 back-to-back (START the cycle after DONE) → BCD=0x100, then BCD=0x000; BCD holds 0x100 during the second conversion.
- BIN=37 START; at cycle 3 drive BIN=200 and START=1 → ignored, result BCD=0x037, exactly one DONE.
- BIN=99 START; assert RESET at cycle 4 → next cycle BUSY=0, BCD=0x000, no DONE.
- With OUTPUT_BCD_AUTO_START_EN, START tied 0: BIN steps 0→42→42→7 → exactly two DONE pulses; BCD=0x042, then 0x007.
